// File: rtl/md_ctrl_if.sv
// Multiply/divide interface between the E stage, the hazard unit and md_ctrl.
interface md_ctrl_if;
    logic [3:0]  MDOp_E;
    logic [31:0] E_V1;
    logic [31:0] E_V2;
    logic        D_is_md;
    logic        busy;
    logic        stall_MD;
    logic [31:0] E_MDout;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline side: drives ops/operands, observes results and stall
    modport master (
        output MDOp_E, E_V1, E_V2, D_is_md,
        input  busy, stall_MD, E_MDout, HI, LO
    );

    // Sequencer side
    modport slave (
        input  MDOp_E, E_V1, E_V2, D_is_md,
        output busy, stall_MD, E_MDout, HI, LO
    );
endinterface

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models fixed latency with a busy
// countdown and requests a D-stage stall while an operation is in flight.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_ctrl_if.slave   bus
);
    localparam logic [3:0] C_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] C_DIV  = 4'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_we;

    logic        w_busy;
    logic        w_is_mult;
    logic        w_is_div;
    logic        w_start;

    // Multiplier: operands widened to 64 bits so the low 64 product bits are exact
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_prod;

    // Divider works on magnitudes; signs are reapplied afterwards. This keeps
    // 0x80000000 / -1 well defined (quotient wraps to 0x80000000, remainder 0).
    logic        w_div_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_zero;

    assign w_busy    = (r_state == RUN);
    assign w_is_mult = (bus.MDOp_E == OP_MULT) || (bus.MDOp_E == OP_MULTU);
    assign w_is_div  = (bus.MDOp_E == OP_DIV)  || (bus.MDOp_E == OP_DIVU);
    assign w_start   = (w_is_mult || w_is_div) && !w_busy;

    assign w_prod_s = $signed({{32{bus.E_V1[31]}}, bus.E_V1}) * $signed({{32{bus.E_V2[31]}}, bus.E_V2});
    assign w_prod_u = {32'd0, bus.E_V1} * {32'd0, bus.E_V2};
    assign w_prod   = (bus.MDOp_E == OP_MULT) ? w_prod_s : w_prod_u;

    assign w_div_sgn  = (bus.MDOp_E == OP_DIV);
    assign w_a_neg    = w_div_sgn && bus.E_V1[31];
    assign w_b_neg    = w_div_sgn && bus.E_V2[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - bus.E_V1) : bus.E_V1;
    assign w_b_mag    = w_b_neg ? (32'd0 - bus.E_V2) : bus.E_V2;
    assign w_div_zero = (bus.E_V2 == 32'd0);
    // Keep the divider away from a zero divisor; the result is discarded anyway
    assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
    assign w_q_mag    = w_a_mag / w_b_safe;
    assign w_r_mag    = w_a_mag % w_b_safe;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: leave IDLE on start, return when the countdown reaches its last cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_start)       w_state_next = RUN;
            RUN:  if (r_cnt == 4'd1) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Countdown, pending result capture, HI/LO commit and mthi/mtlo writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else if (w_start) begin
            r_cnt <= w_is_mult ? C_MULT : C_DIV;
            if (w_is_mult) begin
                r_pend_hi <= w_prod[63:32];
                r_pend_lo <= w_prod[31:0];
                r_pend_we <= 1'b1;
            end else begin
                r_pend_hi <= w_rem;
                r_pend_lo <= w_quot;
                r_pend_we <= !w_div_zero;
            end
        end else if (w_busy) begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_cnt == 4'd1) begin
                r_pend_we <= 1'b0;
                if (r_pend_we) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end
        end else begin
            if (bus.MDOp_E == OP_MTHI) r_hi <= bus.E_V1;
            if (bus.MDOp_E == OP_MTLO) r_lo <= bus.E_V1;
        end
    end

    // Read mux for mfhi/mflo
    always_comb begin
        bus.E_MDout = 32'd0;
        if (bus.MDOp_E == OP_MFHI) bus.E_MDout = r_hi;
        if (bus.MDOp_E == OP_MFLO) bus.E_MDout = r_lo;
    end

    assign bus.busy     = w_busy;
    assign bus.stall_MD = bus.D_is_md && (w_start || w_busy);
    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;
endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: expected HI/LO/latency pushed at issue, popped at completion.
module tb_md_ctrl;
    logic clk;
    logic reset;
    md_ctrl_if mif();

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // An MD start while busy must never be presented
    always @(negedge clk) begin
        if (reset && mif.busy && mif.MDOp_E >= 4'd1 && mif.MDOp_E <= 4'd4) begin
            errors++;
            $error("FAIL busy_issue op=%0d while busy", mif.MDOp_E);
        end
    end

    // Reference model of the architectural effect of one MD operation
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        int          q;
        int          r;
        e.cycles = (op <= 4'd2) ? 5 : 10;
        case (op)
            4'd1: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            4'd2: begin
                p = 64'(a) * 64'(b);
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            4'd3: if (b != 32'd0) begin
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    m_lo = 32'h80000000; m_hi = 32'd0;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    m_lo = q; m_hi = r;
                end
            end
            4'd4: if (b != 32'd0) begin
                m_lo = a / b; m_hi = a % b;
            end
            default: ;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue one MD op, count busy/stall cycles, compare against the scoreboard
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic dmd);
        exp_t e;
        int   nb;
        int   ns;
        sb.push_back(model(op, a, b));
        mif.MDOp_E = op; mif.E_V1 = a; mif.E_V2 = b; mif.D_is_md = dmd;
        #1;
        check({tag, "_stall_start"}, 64'(mif.stall_MD), 64'(dmd));
        ns = mif.stall_MD ? 1 : 0;
        step();
        mif.MDOp_E = 4'd0;
        #1;
        nb = 0;
        while (mif.busy && nb < 40) begin
            nb++;
            if (mif.stall_MD) ns++;
            step();
        end
        e = sb.pop_front();
        check({tag, "_busy_cycles"}, 64'(nb), 64'(e.cycles));
        check({tag, "_HI"}, 64'(mif.HI), 64'(e.hi));
        check({tag, "_LO"}, 64'(mif.LO), 64'(e.lo));
        if (dmd) check({tag, "_stall_cycles"}, 64'(ns), 64'(e.cycles + 1));
        $display("txn %s op=%0d a=0x%08h b=0x%08h busy=%0d HI=0x%08h LO=0x%08h",
                 tag, op, a, b, nb, mif.HI, mif.LO);
        mif.D_is_md = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b0;
        mif.MDOp_E = 4'd0; mif.E_V1 = 32'd0; mif.E_V2 = 32'd0; mif.D_is_md = 1'b1;
        #1;
        check("rst_busy", 64'(mif.busy), 64'd0);
        check("rst_HI", 64'(mif.HI), 64'd0);
        check("rst_LO", 64'(mif.LO), 64'd0);
        check("rst_stall", 64'(mif.stall_MD), 64'd0);
        step(); step();
        reset = 1'b1;
        mif.D_is_md = 1'b0;
        step();

        run_op("mult_m1x2", 4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("t1_HI_const", 64'(mif.HI), 64'hFFFFFFFF);
        check("t1_LO_const", 64'(mif.LO), 64'hFFFFFFFE);
        run_op("multu_m1x2", 4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("t2_HI_const", 64'(mif.HI), 64'h00000001);
        run_op("div_m7d2", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("t3_LO_const", 64'(mif.LO), 64'hFFFFFFFD);
        check("t3_HI_const", 64'(mif.HI), 64'hFFFFFFFF);
        run_op("divu_7d0", 4'd4, 32'd7, 32'd0, 1'b0);
        check("t3_div0_LO_kept", 64'(mif.LO), 64'hFFFFFFFD);
        run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);

        // mult with an MD op waiting in D, then mflo reads the new LO
        run_op("mult_stall", 4'd1, 32'd12345, 32'hFFFFFF00, 1'b1);
        mif.MDOp_E = 4'd6; mif.D_is_md = 1'b1;
        #1;
        check("t4_mflo", 64'(mif.E_MDout), 64'(m_lo));
        check("t4_no_stall", 64'(mif.stall_MD), 64'd0);
        mif.D_is_md = 1'b0;

        // mthi / mtlo then read back
        step();
        mif.MDOp_E = 4'd7; mif.E_V1 = 32'h00001234;
        step();
        mif.MDOp_E = 4'd5;
        #1;
        check("t5_mfhi", 64'(mif.E_MDout), 64'h00001234);
        check("t5_busy", 64'(mif.busy), 64'd0);
        mif.MDOp_E = 4'd8; mif.E_V1 = 32'hCAFEF00D;
        step();
        mif.MDOp_E = 4'd6;
        #1;
        check("t5_mflo", 64'(mif.E_MDout), 64'hCAFEF00D);
        mif.MDOp_E = 4'd9;
        #1;
        check("op9_MDout", 64'(mif.E_MDout), 64'd0);
        m_hi = 32'h00001234; m_lo = 32'hCAFEF00D;
        step();

        // random operands
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 5) ? 32'(-$urandom_range(1, 1000)) : $urandom_range(1, 32'h0FFFFFFF);
            case (i % 3)
                0: run_op("rnd_mult", 4'd1, ra, rb, 1'b0);
                1: run_op("rnd_divu", 4'd4, ra, rb, 1'b0);
                default: run_op("rnd_div", 4'd3, ra, rb, 1'b0);
            endcase
        end

        // reset in busy cycle 3 of a divide
        mif.MDOp_E = 4'd3; mif.E_V1 = 32'd100; mif.E_V2 = 32'd7;
        step();
        mif.MDOp_E = 4'd0;
        step(); step();
        check("t6_busy_before", 64'(mif.busy), 64'd1);
        reset = 1'b0;
        mif.D_is_md = 1'b1;
        #1;
        check("t6_busy", 64'(mif.busy), 64'd0);
        check("t6_HI", 64'(mif.HI), 64'd0);
        check("t6_LO", 64'(mif.LO), 64'd0);
        check("t6_stall", 64'(mif.stall_MD), 64'd0);
        $display("txn reset_mid_div busy=%0d HI=0x%08h LO=0x%08h", mif.busy, mif.HI, mif.LO);
        mif.D_is_md = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        step(); step();
        reset = 1'b1;
        step();
        run_op("mult_after_rst", 4'd1, 32'd3, 32'd4, 1'b0);
        check("t6_LO_const", 64'(mif.LO), 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
